// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a one-bit full-add cell.
// Operands are captured on an accepted start, processed LSB first one bit per
// clock, and the assembled sum is published together with the final carry.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, honoured in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on the accepted start edge
//   sub    in   1      subtract select (only with SERIAL_ADD_SUB_EN)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, sum/cout valid
//   sum    out  WIDTH  result, held until the next accepted start completes
//   cout   out  1      final carry (add: overflow, sub: 1 = no borrow)
//
// Build option: define SERIAL_ADD_SUB_EN to add the sub port (a - b mod 2^WIDTH).
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, b_sr_q, sum_sr_q;
   logic [WIDTH-1:0]   sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, cout_q;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               sub_c;
   logic               accept_c;
   logic               last_c;
   logic               bit_c;
   logic               carry_nxt_c;
   logic [WIDTH-1:0]   b_load_c;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_c = sub;
`else
   assign sub_c = 1'b0;
`endif

   // One-bit add cell on the current LSBs.
   assign bit_c       = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign carry_nxt_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

   // Subtraction is a + ~b + 1: invert B at capture and seed carry with 1.
   assign b_load_c = sub_c ? ~b : b;
   assign accept_c = start && (state_q != ST_RUN);
   assign last_c   = (state_q == ST_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_c) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from next state, registered below so busy/done are flops.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_RUN:  busy_d = 1'b1;
         ST_DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   // Handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Serial datapath: operand shifters, carry flop, bit counter, sum assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else if (accept_c) begin
         a_sr_q  <= a;
         b_sr_q  <= b_load_c;
         carry_q <= sub_c;
         cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
         a_sr_q   <= a_sr_q >> 1;
         b_sr_q   <= b_sr_q >> 1;
         sum_sr_q <= {bit_c, sum_sr_q[WIDTH-1:1]};
         carry_q  <= carry_nxt_c;
         cnt_q    <= cnt_q + CNT_W'(1);
         // Publish only on the final bit so shifting never shows on sum.
         if (last_c) begin
            sum_q  <= {bit_c, sum_sr_q[WIDTH-1:1]};
            cout_q <= carry_nxt_c;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an
// arithmetic reference model; a second 4-bit instance is swept exhaustively.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       sub_r = 1'b0;
   logic       busy, done, cout;
   logic [7:0] sum;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub_r),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (1'b0),
`endif
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   // Reference: plain unsigned arithmetic, result as {cout, sum}.
   function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic [8:0] r;
      if (s) begin
         r[7:0] = x - y;
         r[8]   = (x >= y);
      end else begin
         r = {1'b0, x} + {1'b0, y};
      end
      return r;
   endfunction

   // Drive one start pulse and wait (bounded) for done; report what was seen.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        output logic [7:0] s, output logic c, output int lat,
                        output int busy_n, output logic stable, output logic overlap);
      logic [7:0] s0;
      @(negedge clk);
      a = av; b = bv; sub_r = sv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_n = 0; stable = 1'b1; overlap = 1'b0; s0 = sum;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         if (sum !== s0) stable = 1'b0;
         a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
         lat++;
      end
      if (busy && done) overlap = 1'b1;
      s = sum; c = cout;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, cout, sum} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] xs [3] = '{8'h05, 8'hFF, 8'hFF};
      logic [7:0] ys [3] = '{8'h03, 8'h01, 8'hFF};
      logic [8:0] want [3] = '{9'h008, 9'h100, 9'h1FE};
      logic [7:0] s; logic c, st, ov; int lat, bn;
      for (int i = 0; i < 3; i++) begin
         do_op(xs[i], ys[i], 1'b0, s, c, lat, bn, st, ov);
         vectors++;
         if ({c, s} !== want[i]) begin
            miscompares++;
            $display("FAIL directed_%0d: got {cout,sum}=%h, want %h", i, {c, s}, want[i]);
         end
         vectors++;
         if (lat !== 8 || bn !== 8) begin
            miscompares++;
            $display("FAIL directed_timing_%0d: got latency=%0d busy=%0d, want 8/8", i, lat, bn);
         end
         vectors++;
         if (!st || ov) begin
            miscompares++;
            $display("FAIL directed_visibility_%0d: got stable=%b overlap=%b, want 1/0", i, st, ov);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] x, y, s; logic sv, c, st, ov; int lat, bn;
      for (int i = 0; i < 40; i++) begin
         x = 8'($urandom); y = 8'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         sv = 1'($urandom);
`else
         sv = 1'b0;
`endif
         do_op(x, y, sv, s, c, lat, bn, st, ov);
         vectors++;
         if ({c, s} !== model(x, y, sv) || lat !== 8 || !st || ov) begin
            miscompares++;
            $display("FAIL random_%0d: a=%h b=%h sub=%b got {cout,sum}=%h lat=%0d, want %h lat=8",
                     i, x, y, sv, {c, s}, lat, model(x, y, sv));
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      a = 8'h11; b = 8'h22; sub_r = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'h40; b = 8'h41;
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      vectors++;
      if ({cout, sum} !== 9'h033) begin
         miscompares++;
         $display("FAIL b2b_first: got {cout,sum}=%h, want 033", {cout, sum});
      end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_no_idle: got busy=%b, want 1", busy);
      end
      n = 0;
      while (!done && n < 40) begin @(negedge clk); n++; end
      vectors++;
      if ({cout, sum} !== 9'h081) begin
         miscompares++;
         $display("FAIL b2b_second: got {cout,sum}=%h, want 081", {cout, sum});
      end
   endtask

   task automatic test_abort();
      logic [7:0] s; logic c, st, ov, seen; int lat, bn;
      @(negedge clk);
      a = 8'hA5; b = 8'h5A; sub_r = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, cout, sum} !== 11'd0) begin
         miscompares++;
         $display("FAIL abort_clear: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (done) seen = 1'b1; end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_done: got done pulse=%b, want 0", seen);
      end
      do_op(8'h10, 8'h20, 1'b0, s, c, lat, bn, st, ov);
      vectors++;
      if ({c, s} !== 9'h030 || lat !== 8) begin
         miscompares++;
         $display("FAIL abort_next_op: got {cout,sum}=%h lat=%0d, want 030 lat=8", {c, s}, lat);
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      logic [7:0] s; logic c, st, ov; int lat, bn;
      do_op(8'h05, 8'h03, 1'b1, s, c, lat, bn, st, ov);
      vectors++;
      if ({c, s} !== 9'h102) begin
         miscompares++;
         $display("FAIL sub_5_3: got {cout,sum}=%h, want 102", {c, s});
      end
      do_op(8'h03, 8'h05, 1'b1, s, c, lat, bn, st, ov);
      vectors++;
      if ({c, s} !== 9'h0FE) begin
         miscompares++;
         $display("FAIL sub_3_5: got {cout,sum}=%h, want 0FE", {c, s});
      end
   endtask
`endif

   task automatic test_sweep4();
      int n;
      logic [4:0] want;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            @(negedge clk);
            a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 20) begin @(negedge clk); n++; end
            want = 5'(x + y);
            vectors++;
            if ({cout4, sum4} !== want || n !== 4) begin
               miscompares++;
               $display("FAIL sweep4 a=%0d b=%0d: got {cout,sum}=%h lat=%0d, want %h lat=4",
                        x, y, {cout4, sum4}, n, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      test_sweep4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
